// File: rtl/grf_wport_arbiter_pkg.sv
// Shared widths, defaults and the FIFO entry type for the GRF write-port arbiter.
package grf_wport_arbiter_pkg;

  localparam int GRF_AW         = 5;
  localparam int GRF_DW         = 32;
  localparam int NREGS          = 2 ** GRF_AW;
  localparam int WPORT_DEPTH    = 2;
  localparam int WPORT_MAX_WAIT = 4;
  localparam int WAIT_W         = 4;

  typedef struct packed {
    logic [GRF_AW-1:0] a3;
    logic [GRF_DW-1:0] wd;
  } wport_entry_t;

  // Register 0 is hardwired, so it never appears as a pending destination.
  function automatic logic [NREGS-1:0] reg_onehot(input logic [GRF_AW-1:0] a3);
    reg_onehot     = '0;
    reg_onehot[a3] = 1'b1;
    reg_onehot[0]  = 1'b0;
  endfunction

endpackage

// File: rtl/grf_wport_arbiter_fifo.sv
// In-order buffer for secondary GRF writes; exposes every slot so the top can build pend_mask.
module wport_fifo
  import grf_wport_arbiter_pkg::*;
#(
  parameter int DEPTH = WPORT_DEPTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  wport_entry_t                 push_ent,
  input  logic                         pop,
  output logic                         full,
  output logic                         empty,
  output wport_entry_t                 head,
  output wport_entry_t [DEPTH-1:0]     ents,
  output logic         [DEPTH-1:0]     vlds
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic         [PW-1:0]    wr_ptr;
  logic         [PW-1:0]    rd_ptr;
  logic         [CW-1:0]    count;
  logic         [DEPTH-1:0] vld;
  wport_entry_t [DEPTH-1:0] mem;
  logic                     do_push;
  logic                     do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      vld    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr      <= wr_ptr + PW'(1);
        vld[wr_ptr] <= 1'b1;
      end
      if (do_pop) begin
        rd_ptr      <= rd_ptr + PW'(1);
        vld[rd_ptr] <= 1'b0;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage carries no reset; slot validity lives in vld.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_ent;
  end

  assign head = mem[rd_ptr];
  assign ents = mem;
  assign vlds = vld;

endmodule

// File: rtl/grf_wport_arbiter.sv
// Single GRF write port shared between W-stage writeback (always wins) and a buffered
// secondary producer that drains into idle W slots.
module grf_wport_arbiter
  import grf_wport_arbiter_pkg::*;
#(
  parameter int DEPTH    = WPORT_DEPTH,
  parameter int MAX_WAIT = WPORT_MAX_WAIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              w_we,
  input  logic [GRF_AW-1:0] w_a3,
  input  logic [GRF_DW-1:0] w_wd,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [GRF_AW-1:0] s_a3,
  input  logic [GRF_DW-1:0] s_wd,
  output logic              grf_we,
  output logic [GRF_AW-1:0] grf_a3,
  output logic [GRF_DW-1:0] grf_wd,
  output logic [NREGS-1:0]  pend_mask,
  output logic              starve_stall,
  output logic              waw_err
);

  localparam logic [WAIT_W-1:0] WAIT_TOP = WAIT_W'(MAX_WAIT);

  logic                     w_busy;
  logic                     full;
  logic                     empty;
  logic                     push;
  logic                     pop;
  wport_entry_t             push_ent;
  wport_entry_t             head;
  wport_entry_t [DEPTH-1:0] ents;
  logic         [DEPTH-1:0] vlds;
  logic [WAIT_W-1:0]        wait_cnt;
  logic                     waw_q;

  assign w_busy = w_we & (w_a3 != '0);

  // Ready comes only from registered occupancy, so a same-cycle pop never frees a full FIFO.
  assign s_ready  = reset & ~full;
  assign push     = s_valid & s_ready & (s_a3 != '0);
  assign pop      = reset & ~w_busy & ~empty;
  assign push_ent = '{a3: s_a3, wd: s_wd};

  wport_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_ent (push_ent),
    .pop      (pop),
    .full     (full),
    .empty    (empty),
    .head     (head),
    .ents     (ents),
    .vlds     (vlds)
  );

  always_comb begin
    grf_we = 1'b0;
    grf_a3 = '0;
    grf_wd = '0;
    if (reset) begin
      if (w_busy) begin
        grf_we = 1'b1;
        grf_a3 = w_a3;
        grf_wd = w_wd;
      end else if (!empty) begin
        grf_we = 1'b1;
        grf_a3 = head.a3;
        grf_wd = head.wd;
      end
    end
  end

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vlds[i]) pend_mask = pend_mask | reg_onehot(ents[i].a3);
    end
  end

  // Head-of-line wait: counts blocked cycles, saturates, clears when the head finally drains.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (pop) begin
      wait_cnt <= '0;
    end else if (!empty && w_busy && (wait_cnt != WAIT_TOP)) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  assign starve_stall = (wait_cnt == WAIT_TOP);

  // W data is still written on a collision; the flag only records that ordering was broken.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      waw_q <= 1'b0;
    end else if (w_busy && pend_mask[w_a3]) begin
      waw_q <= 1'b1;
    end
  end

  assign waw_err = waw_q;

endmodule

// File: tb/tb_grf_wport_arbiter.sv
// Cycle-stepped bench: a queue model of the secondary FIFO predicts every GRF write.
module tb_grf_wport_arbiter;

  localparam int DEPTH = 2;
  localparam int MAXW  = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        w_we;
  logic [4:0]  w_a3;
  logic [31:0] w_wd;
  logic        s_valid;
  logic        s_ready;
  logic [4:0]  s_a3;
  logic [31:0] s_wd;
  logic        grf_we;
  logic [4:0]  grf_a3;
  logic [31:0] grf_wd;
  logic [31:0] pend_mask;
  logic        starve_stall;
  logic        waw_err;

  int total = 0;
  int bad   = 0;

  logic [36:0] mq[$];
  int          mwait = 0;
  logic        mwaw  = 1'b0;

  always #5 clk = ~clk;

  grf_wport_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAXW)) dut (
    .clk          (clk),
    .reset        (reset),
    .w_we         (w_we),
    .w_a3         (w_a3),
    .w_wd         (w_wd),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_a3         (s_a3),
    .s_wd         (s_wd),
    .grf_we       (grf_we),
    .grf_a3       (grf_a3),
    .grf_wd       (grf_wd),
    .pend_mask    (pend_mask),
    .starve_stall (starve_stall),
    .waw_err      (waw_err)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", tag, act, exp, $time);
    end
  endtask

  task automatic chk_reset_outs();
    chk("rst_grf", {grf_we, grf_a3, grf_wd}, 64'd0);
    chk("rst_rdy", s_ready, 0);
    chk("rst_pend", pend_mask, 0);
    chk("rst_stall", starve_stall, 0);
    chk("rst_waw", waw_err, 0);
  endtask

  // Check outputs for the current inputs, then advance the model across the next edge.
  task automatic step();
    logic [31:0] epend;
    logic        ebusy, eready, epop, epush;
    #2;
    if (!reset) begin
      chk_reset_outs();
    end else begin
      ebusy  = w_we && (w_a3 != 5'd0);
      eready = (mq.size() < DEPTH);
      epend  = '0;
      foreach (mq[i]) epend[mq[i][36:32]] = 1'b1;
      epend[0] = 1'b0;
      if (ebusy)
        chk("grf_w", {grf_we, grf_a3, grf_wd}, {1'b1, w_a3, w_wd});
      else if (mq.size() > 0)
        chk("grf_s", {grf_we, grf_a3, grf_wd}, {1'b1, mq[0]});
      else
        chk("grf_idle", {grf_we, grf_a3, grf_wd}, 64'd0);
      chk("s_ready", s_ready, eready);
      chk("pend", pend_mask, epend);
      chk("stall", starve_stall, (mwait == MAXW));
      chk("waw", waw_err, mwaw);
      epop  = !ebusy && (mq.size() > 0);
      epush = s_valid && eready && (s_a3 != 5'd0);
      if (ebusy && epend[w_a3]) mwaw = 1'b1;
      if (epop) mwait = 0;
      else if ((mq.size() > 0) && ebusy && (mwait < MAXW)) mwait++;
      if (epop) void'(mq.pop_front());
      if (epush) mq.push_back({s_a3, s_wd});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic sv, input logic [4:0] sa, input logic [31:0] sd);
    w_we = we; w_a3 = wa; w_wd = wd;
    s_valid = sv; s_a3 = sa; s_wd = sd;
  endtask

  initial begin
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    step();
    drive(1, 5, 32'h55, 1, 6, 32'h66);
    step();
    #1;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    step();

    // W-only write, empty FIFO
    drive(1, 5, 32'h1234, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    step();

    // Secondary drain into idle slot
    drive(0, 0, 0, 1, 8, 32'hCAFE);
    step();
    drive(0, 0, 0, 0, 0, 0);
    chk("t2_pend", pend_mask, 32'h100);
    step();
    chk("t2_pend_clr", pend_mask, 32'h0);
    step();

    // Fill while W busy, then drain in order
    drive(1, 3, 32'h3333, 1, 10, 32'h1);
    step();
    drive(1, 3, 32'h3334, 1, 11, 32'h2);
    step();
    drive(1, 3, 32'h3335, 1, 12, 32'h3);
    chk("t3_full", s_ready, 0);
    step();
    drive(0, 0, 0, 1, 12, 32'h3);
    step();
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) step();

    // Starvation of the head entry
    drive(1, 7, 32'h7777, 1, 13, 32'hD);
    step();
    drive(1, 7, 32'h7778, 0, 0, 0);
    repeat (4) step();
    chk("t4_stall", starve_stall, 1);
    step();
    drive(0, 0, 0, 0, 0, 0);
    step();
    chk("t4_stall_clr", starve_stall, 0);
    step();

    // WAW collision
    drive(1, 7, 32'h1, 1, 9, 32'h99);
    step();
    drive(1, 9, 32'hBEEF, 0, 0, 0);
    step();
    chk("t5_waw", waw_err, 1);
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) step();

    // Asynchronous reset with queued entries
    drive(1, 4, 32'h4, 1, 14, 32'hE);
    step();
    drive(1, 4, 32'h5, 1, 15, 32'hF);
    step();
    #2;
    reset = 1'b0;
    #1;
    chk_reset_outs();
    mq.delete();
    mwait = 0;
    mwaw  = 1'b0;
    @(posedge clk);
    #1;
    step();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) step();
    drive(0, 0, 0, 1, 0, 32'hDEAD);
    chk("t6_rdy_a0", s_ready, 1);
    step();
    drive(0, 0, 0, 0, 0, 0);
    chk("t6_no_write", grf_we, 0);
    repeat (2) step();

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 2) != 0, 5'($urandom_range(0, 31)), $urandom,
            $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom);
      step();
    end
    drive(0, 0, 0, 0, 0, 0);
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
